// File: rtl/musa_if_pkg.sv
// Shared types and constants for the MUSA instruction fetch stage.
package musa_if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// 2-entry shift-style FIFO of fetched {instr, pc}; head always lives in slot 0.
// Flush has priority over push and pop.
module if_fetch_fifo
  import musa_if_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         valid,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         valid_q;
  logic         pop_ok;
  logic         push_ok;

  // Qualify requests against occupancy and compute the next count.
  always_comb begin
    pop_ok  = pop & (count_q != 2'd0);
    push_ok = push & ((count_q != 2'd2) | pop_ok);
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

  // Storage, count and registered valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != 2'd0);
      if (!flush) begin
        if (pop_ok) begin
          mem_q[0] <= mem_q[1];
          if (push_ok) begin
            if (count_q == 2'd1) mem_q[0] <= wdata;
            else                 mem_q[1] <= wdata;
          end
        end else if (push_ok) begin
          if (count_q == 2'd0) mem_q[0] <= wdata;
          else                 mem_q[1] <= wdata;
        end
      end
    end
  end

  assign head  = mem_q[0];
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MUSA IF-stage fetch sequencer: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory and buffers results for decode.
// Optional perf counters (fetch_cnt, stall_cnt) are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit
  import musa_if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              req_q, req_d;
  logic              push_c;
  logic              pop_c;
  logic              room_idle;
  logic              room_wait;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      wentry;

  assign pop_c     = instr_valid & instr_ready;
  assign room_idle = (count != 2'd2);
  // After a push in WAIT the buffer still has room if it was empty or is popping.
  assign room_wait = (count == 2'd0) | pop_c;
  assign wentry    = '{instr: imem_rdata, pc: pend_pc_q};

  // State, PC and registered request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      req_q     <= req_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!redirect && room_idle) state_d = REQ;
      REQ: begin
        if (imem_gnt)      state_d = redirect ? DROP : WAIT;
        else if (redirect) state_d = IDLE;
      end
      WAIT: begin
        if (redirect)         state_d = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_d = room_wait ? REQ : IDLE;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls: PC advance/redirect, pending PC capture, buffer push.
  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    push_c    = 1'b0;
    req_d     = (state_d == REQ);
    if ((state_q == REQ) && imem_gnt) begin
      pend_pc_d = pc_q;
      pc_d      = pc_q + ADDR_W'(1);
    end
    if ((state_q == WAIT) && imem_rvalid && !redirect) push_c = 1'b1;
    if (redirect) pc_d = redirect_pc;
  end

  if_fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect),
    .wdata (wentry),
    .head  (head),
    .valid (instr_valid),
    .count (count)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign instr     = head.instr;
  assign instr_pc  = head.pc;

`ifdef IF_PERF_CNT_EN
  // Saturating counters of buffer pushes and decode back-pressure cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push_c && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (instr_valid && !instr_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch sequencer for the MUSA IF stage. Owns the architectural fetch PC, issues word-addressed read requests to instruction memory over a req/gnt/rvalid handshake, and delivers instruction/PC pairs to the IF/ID boundary through a 2-entry buffer with valid/ready flow control. Taken branches and jumps from later stages redirect it, flushing buffered and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset (word address)
- ADDR_W, 32, PC/address width
- DATA_W, 32, instruction width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req  out  1  read request
- imem_addr  out  ADDR_W  word address of request
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid, at least 1 cycle after gnt
- imem_rdata  in  DATA_W  read data
- redirect  in  1  single-cycle pulse: branch/jump taken
- redirect_pc  in  ADDR_W  new fetch PC
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode accepts head
- instr  out  DATA_W  head instruction
- instr_pc  out  ADDR_W  head instruction address
- fetch_cnt / stall_cnt  out  32  perf counters (IF_PERF_CNT_EN only)

## Operation
- At most one outstanding memory request. Word-addressed: fetch PC advances by +1 on each gnt; 32-bit wrap (32'hFFFF_FFFF -> 0), no flag.
- Buffer: 2 entries of {instr, pc}. Request issued only when occupancy + outstanding < 2.
- FSM states:
  - IDLE: no request. -> REQ when buffer room and no redirect this cycle.
  - REQ: imem_req=1, imem_addr=fetch PC, address stable until gnt. gnt -> WAIT (PC+1, pending pc latched). redirect without gnt -> IDLE (req drops one cycle). redirect with gnt -> DROP.
  - WAIT: rvalid -> write buffer; then REQ if room remains, else IDLE. redirect (with or without rvalid) -> data discarded; rvalid present -> IDLE, absent -> DROP.
  - DROP: discard the next rvalid -> IDLE.
- Redirect: fetch PC := redirect_pc, buffer cleared same edge; flush wins over simultaneous pop and push.
- Pop when instr_valid & instr_ready; simultaneous push and pop on a full buffer allowed.
- Reset (any time, including mid-transaction): state IDLE, buffer empty, fetch PC = RESET_PC; a memory response arriving after reset release with no accepted request is ignored.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, counters 0.
- First imem_req on the first rising edge after rst_n deasserts.
- Data in: rvalid at edge N -> instr_valid at N+1 (registered buffer write).
- Peak throughput with gnt same-cycle, rvalid +1: one instruction per 2 cycles.
- Redirect at edge N -> instr_valid 0 at N+1; request to redirect_pc no earlier than N+1 (IDLE/REQ case) or the cycle after the discarded rvalid (DROP case).

## Configuration
- IF_PERF_CNT_EN defined: fetch_cnt counts buffer pushes; stall_cnt counts cycles with instr_valid=1 and instr_ready=0; both saturate at 32'hFFFF_FFFF, cleared only by reset.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package musa_if_pkg: FSM state enum (IDLE, REQ, WAIT, DROP), RESET_PC default, ADDR_W/DATA_W constants, fetch-entry struct {instr, pc}.
- Sub-module if_fetch_fifo: 2-entry synchronous FIFO with push, pop, flush, count; flush priority over push/pop.

## Test plan
- Reset release, gnt tied 1, rvalid 1 cycle after gnt, instr_ready 1 -> addresses 0,1,2,… every 2 cycles; instr_pc matches; first instr_valid 3 cycles after rst_n rises.
- instr_ready held 0 -> exactly 2 entries buffered, imem_req stays 0; release ready -> entries in order, fetching resumes.
- redirect to 32'h100 while in WAIT, rvalid 2 cycles later -> that data dropped, buffer empty, next imem_addr 32'h100.
- redirect coincident with rvalid and pop on full buffer -> buffer empty next cycle, no stale instr_valid.
- RESET_PC=32'hFFFF_FFFF -> second request address 32'h0.
- rst_n asserted while in WAIT -> outputs at reset values immediately; late rvalid ignored; with IF_PERF_CNT_EN, counters read 0.
